// File: rtl/leb128_decoder_if.sv
// ============================================================================
// Module      : leb128_decoder_if
// Description : Request/byte-stream/result handshake bundle for leb128_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface leb128_decoder_if;
    logic        start;
    logic        is_signed;
    logic        width64;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] value;
    logic [3:0]  len;
    logic [1:0]  error;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output start, is_signed, width64, in_data, in_valid, out_ready,
        input  in_ready, value, len, error, out_valid
    );

    modport slave (
        input  start, is_signed, width64, in_data, in_valid, out_ready,
        output in_ready, value, len, error, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/leb128_decoder.sv
// ============================================================================
// Module      : leb128_decoder
// Description : Byte-serial ULEB128/SLEB128 immediate decoder for i32/i64.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leb128_decoder #(
    parameter bit USE_64B = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    leb128_decoder_if.slave bus
);

    localparam logic [1:0] c_ERR_NONE  = 2'd0;
    localparam logic [1:0] c_ERR_LONG  = 2'd1;
    localparam logic [1:0] c_ERR_OVFL  = 2'd2;
    localparam logic [1:0] c_ERR_UNSUP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_is_signed;
    logic        r_width64;
    logic [63:0] r_acc;
    logic [63:0] r_value;
    logic [3:0]  r_len;
    logic [1:0]  r_error;

    logic        w_unsupported;
    logic        w_consume;
    logic        w_terminal;
    logic        w_at_last;
    logic        w_too_long;
    logic        w_overflow;
    logic [6:0]  w_shamt;
    logic [63:0] w_width_mask;
    logic [63:0] w_shift;
    logic [63:0] w_ext;
    logic [63:0] w_acc_next;
    logic [63:0] w_final;

    assign w_unsupported = bus.width64 && !USE_64B;
    assign w_consume     = (r_state == S_DECODE) && bus.in_valid;
    assign w_terminal    = ~bus.in_data[7];
    assign w_at_last     = (r_len == (r_width64 ? 4'd9 : 4'd4));
    assign w_too_long    = w_at_last && !w_terminal;

    // Byte k lands at bit 7k; shifts past 63 simply drop out of the word.
    assign w_shamt      = 7'(r_len) * 7'd7;
    assign w_width_mask = r_width64 ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    assign w_shift      = 64'(bus.in_data[6:0]) << w_shamt;
    assign w_acc_next   = (r_acc | w_shift) & w_width_mask;

    // Sign fill starts just above this byte; an out-of-range start yields no fill.
    assign w_ext   = (r_is_signed && bus.in_data[6]) ? ({64{1'b1}} << (w_shamt + 7'd7)) : 64'd0;
    assign w_final = (w_acc_next | w_ext) & w_width_mask;

    always_comb begin
        w_overflow = 1'b0;
        if (w_at_last && w_terminal) begin
            if (r_width64) begin
                if (r_is_signed)
                    w_overflow = !((bus.in_data[6:0] == 7'h00) || (bus.in_data[6:0] == 7'h7F));
                else
                    w_overflow = |bus.in_data[6:1];
            end else begin
                if (r_is_signed)
                    w_overflow = !((bus.in_data[6:3] == 4'h0) || (bus.in_data[6:3] == 4'hF));
                else
                    w_overflow = |bus.in_data[6:4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_state_next = w_unsupported ? S_DONE : S_DECODE;
            end
            S_DECODE: begin
                if (w_consume && (w_terminal || w_at_last))
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_signed <= 1'b0;
            r_width64   <= 1'b0;
            r_acc       <= 64'd0;
            r_value     <= 64'd0;
            r_len       <= 4'd0;
            r_error     <= c_ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_signed <= bus.is_signed;
                        r_width64   <= bus.width64;
                        r_acc       <= 64'd0;
                        r_value     <= 64'd0;
                        r_len       <= 4'd0;
                        r_error     <= w_unsupported ? c_ERR_UNSUP : c_ERR_NONE;
                    end
                end
                S_DECODE: begin
                    if (w_consume) begin
                        r_acc <= w_acc_next;
                        r_len <= r_len + 4'd1;
                        if (w_too_long) begin
                            r_error <= c_ERR_LONG;
                            r_value <= 64'd0;
                        end else if (w_terminal) begin
                            if (w_overflow) begin
                                r_error <= c_ERR_OVFL;
                                r_value <= 64'd0;
                            end else begin
                                r_value <= w_final;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_DECODE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.value     = r_value;
    assign bus.len       = r_len;
    assign bus.error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_leb128_decoder.sv
// ============================================================================
// Module      : tb_leb128_decoder
// Description : Directed self-checking bench for leb128_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_leb128_decoder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    leb128_decoder_if bus();
    leb128_decoder_if bus32();

    leb128_decoder #(.USE_64B(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    leb128_decoder #(.USE_64B(1'b0)) dut_no64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] stim [0:15];

    task automatic idle_inputs;
        bus.start     = 1'b0;  bus.is_signed   = 1'b0;  bus.width64   = 1'b0;
        bus.in_data   = 8'h00; bus.in_valid    = 1'b0;  bus.out_ready = 1'b0;
        bus32.start   = 1'b0;  bus32.is_signed = 1'b0;  bus32.width64 = 1'b0;
        bus32.in_data = 8'h00; bus32.in_valid  = 1'b0;  bus32.out_ready = 1'b0;
    endtask

    // Issues a request, streams n bytes from stim[], then waits (bounded) for out_valid.
    task automatic run_decode(input logic s, input logic w64, input int n);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = s; bus.width64 = w64;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_data  = stim[i];
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout out_valid=%b required=1", bus.out_valid);
        end
    endtask

    task automatic accept;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        checks++;
        if ({bus.value, bus.len, bus.error} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs value=%h len=%0d error=%0d required=0", bus.value, bus.len, bus.error);
        end
        checks++;
        if ({bus.out_valid, bus.in_ready, bus32.out_valid, bus32.in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b required=0000", {bus.out_valid, bus.in_ready, bus32.out_valid, bus32.in_ready});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_i32;
        stim[0] = 8'hE5; stim[1] = 8'h8E; stim[2] = 8'h26;
        run_decode(1'b0, 1'b0, 3);
        checks++;
        if (bus.value !== 64'h0000_0000_0009_8765) begin
            errors++; $display("FAIL u32_value got=%h required=%h", bus.value, 64'h98765);
        end
        checks++;
        if (bus.len !== 4'd3 || bus.error !== 2'd0) begin
            errors++; $display("FAIL u32_len_err got len=%0d err=%0d required len=3 err=0", bus.len, bus.error);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL u32_in_ready_done got=%b required=0", bus.in_ready);
        end
        accept();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL u32_after_accept out_valid=%b required=0", bus.out_valid);
        end
    endtask

    task automatic test_signed;
        stim[0] = 8'h7F;
        run_decode(1'b1, 1'b1, 1);
        checks++;
        if (bus.value !== 64'hFFFF_FFFF_FFFF_FFFF || bus.len !== 4'd1) begin
            errors++; $display("FAIL s64_minus1 got=%h len=%0d required=ffffffffffffffff len=1", bus.value, bus.len);
        end
        accept();
        stim[0] = 8'h80; stim[1] = 8'h7F;
        run_decode(1'b1, 1'b0, 2);
        checks++;
        if (bus.value !== 64'h0000_0000_FFFF_FF80 || bus.len !== 4'd2) begin
            errors++; $display("FAIL s32_minus128 got=%h len=%0d required=00000000ffffff80 len=2", bus.value, bus.len);
        end
        accept();
        stim[0] = 8'hC0; stim[1] = 8'hBB; stim[2] = 8'h78;
        run_decode(1'b1, 1'b0, 3);
        checks++;
        if (bus.value !== 64'h0000_0000_FFFE_1DC0) begin
            errors++; $display("FAIL s32_neg123456 got=%h required=00000000fffe1dc0", bus.value);
        end
        accept();
        run_decode(1'b1, 1'b1, 3);
        checks++;
        if (bus.value !== 64'hFFFF_FFFF_FFFE_1DC0) begin
            errors++; $display("FAIL s64_neg123456 got=%h required=fffffffffffe1dc0", bus.value);
        end
        accept();
        stim[0] = 8'h3F;
        run_decode(1'b1, 1'b1, 1);
        checks++;
        if (bus.value !== 64'h0000_0000_0000_003F) begin
            errors++; $display("FAIL s64_pos63 got=%h required=000000000000003f", bus.value);
        end
        accept();
    endtask

    task automatic test_i32_boundary;
        for (int i = 0; i < 4; i++) stim[i] = 8'hFF;
        stim[4] = 8'h0F;
        run_decode(1'b0, 1'b0, 5);
        checks++;
        if (bus.value !== 64'h0000_0000_FFFF_FFFF || bus.len !== 4'd5 || bus.error !== 2'd0) begin
            errors++; $display("FAIL u32_max got=%h len=%0d err=%0d required=00000000ffffffff len=5 err=0", bus.value, bus.len, bus.error);
        end
        accept();
        stim[4] = 8'h1F;
        run_decode(1'b0, 1'b0, 5);
        checks++;
        if (bus.error !== 2'd2 || bus.value !== 64'd0) begin
            errors++; $display("FAIL u32_ovfl got err=%0d value=%h required err=2 value=0", bus.error, bus.value);
        end
        accept();
        stim[4] = 8'h7F;
        run_decode(1'b1, 1'b0, 5);
        checks++;
        if (bus.value !== 64'h0000_0000_FFFF_FFFF || bus.error !== 2'd0) begin
            errors++; $display("FAIL s32_5byte got=%h err=%0d required=00000000ffffffff err=0", bus.value, bus.error);
        end
        accept();
        stim[4] = 8'h0F;
        run_decode(1'b1, 1'b0, 5);
        checks++;
        if (bus.error !== 2'd2 || bus.value !== 64'd0) begin
            errors++; $display("FAIL s32_ovfl got err=%0d value=%h required err=2 value=0", bus.error, bus.value);
        end
        accept();
    endtask

    task automatic test_unsigned_i64;
        for (int i = 0; i < 9; i++) stim[i] = 8'hFF;
        stim[9] = 8'h01;
        run_decode(1'b0, 1'b1, 10);
        checks++;
        if (bus.value !== 64'hFFFF_FFFF_FFFF_FFFF || bus.len !== 4'd10 || bus.error !== 2'd0) begin
            errors++; $display("FAIL u64_max got=%h len=%0d err=%0d required=ffffffffffffffff len=10 err=0", bus.value, bus.len, bus.error);
        end
        accept();
        stim[9] = 8'h02;
        run_decode(1'b0, 1'b1, 10);
        checks++;
        if (bus.error !== 2'd2 || bus.value !== 64'd0 || bus.len !== 4'd10) begin
            errors++; $display("FAIL u64_ovfl got err=%0d value=%h len=%0d required err=2 value=0 len=10", bus.error, bus.value, bus.len);
        end
        accept();
    endtask

    task automatic test_too_long;
        for (int i = 0; i < 5; i++) stim[i] = 8'h80;
        run_decode(1'b0, 1'b0, 5);
        checks++;
        if (bus.error !== 2'd1 || bus.len !== 4'd5 || bus.value !== 64'd0) begin
            errors++; $display("FAIL too_long got err=%0d len=%0d value=%h required err=1 len=5 value=0", bus.error, bus.len, bus.value);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL too_long_in_ready got=%b required=0", bus.in_ready);
        end
        accept();
    endtask

    task automatic test_unsupported;
        @(negedge clk);
        bus32.start = 1'b1; bus32.width64 = 1'b1; bus32.in_valid = 1'b1; bus32.in_data = 8'h05;
        @(negedge clk);
        bus32.start = 1'b0;
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.error !== 2'd3 || bus32.len !== 4'd0 || bus32.value !== 64'd0) begin
            errors++; $display("FAIL unsup_result got ov=%b err=%0d len=%0d value=%h required ov=1 err=3 len=0 value=0",
                               bus32.out_valid, bus32.error, bus32.len, bus32.value);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus32.in_ready !== 1'b0) begin
                errors++; $display("FAIL unsup_in_ready cycle=%0d got=%b required=0", i, bus32.in_ready);
            end
            @(negedge clk);
        end
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        bus32.width64 = 1'b0;
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0) begin
            errors++; $display("FAIL unsup_accept got ov=%b rdy=%b required 0 0", bus32.out_valid, bus32.in_ready);
        end
    endtask

    task automatic test_backpressure;
        stim[0] = 8'hE5; stim[1] = 8'h8E; stim[2] = 8'h26;
        run_decode(1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            bus.start    = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.value !== 64'h98765 || bus.len !== 4'd3 || bus.error !== 2'd0) begin
                errors++; $display("FAIL hold cycle=%0d got ov=%b value=%h len=%0d err=%0d required ov=1 value=98765 len=3 err=0",
                                   i, bus.out_valid, bus.value, bus.len, bus.error);
            end
        end
        bus.in_valid = 1'b0; bus.start = 1'b0; bus.in_data = 8'h00;
        accept();
    endtask

    task automatic test_back_to_back;
        stim[0] = 8'h05;
        run_decode(1'b0, 1'b0, 1);
        checks++;
        if (bus.value !== 64'd5 || bus.len !== 4'd1) begin
            errors++; $display("FAIL b2b_first got=%h len=%0d required=5 len=1", bus.value, bus.len);
        end
        bus.out_ready = 1'b1; bus.start = 1'b1; bus.is_signed = 1'b0; bus.width64 = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got ov=%b rdy=%b required 0 0", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_restart in_ready=%b required=1", bus.in_ready);
        end
        bus.in_data = 8'h2A; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.value !== 64'h2A || bus.len !== 4'd1) begin
            errors++; $display("FAIL b2b_second got ov=%b value=%h len=%0d required ov=1 value=2a len=1", bus.out_valid, bus.value, bus.len);
        end
        accept();
    endtask

    task automatic test_reset_mid_decode;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.width64 = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_data = 8'h80; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_data = 8'h81;
        checks++;
        if (bus.len !== 4'd1 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_progress got len=%0d rdy=%b required len=1 rdy=1", bus.len, bus.in_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.value, bus.len, bus.error, bus.out_valid, bus.in_ready} !== 72'd0) begin
            errors++; $display("FAIL async_reset got value=%h len=%0d err=%0d ov=%b rdy=%b required all 0",
                               bus.value, bus.len, bus.error, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.in_data = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle cycle=%0d got rdy=%b ov=%b required 0 0", i, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_unsigned_i32();
        test_signed();
        test_i32_boundary();
        test_unsigned_i64();
        test_too_long();
        test_unsupported();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
